// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the single write port of a fifo among NUM_REQ
// producers. Round-robin grant with at most BURST_LEN words per grant, one
// IDLE arbitration cycle between grants, and no write issued while full.
module fifo_wr_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned BURST_LEN  = 4
) (
   input  logic                            clock,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic                            fifo_full,
   output logic                            fifo_wr,
   output logic [DATA_WIDTH-1:0]           fifo_wr_data,
   output logic [$clog2(NUM_REQ)-1:0]      grant_id,
   output logic                            busy
);

   localparam int unsigned IDW = $clog2(NUM_REQ);
   localparam int unsigned BCW = $clog2(BURST_LEN) + 1;
   localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_LEN - 1);
   localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

   typedef enum logic {
      S_IDLE,
      S_GRANT
   } state_t;

   state_t               r_state;
   logic [IDW-1:0]       r_owner;
   logic [IDW-1:0]       r_ptr;
   logic [BCW-1:0]       r_beat_cnt;
   logic [IDW-1:0]       r_grant_id;
   logic                 r_busy;

   logic [IDW-1:0]       w_pick;
   logic                 w_any;
   int unsigned          w_best;
   logic                 w_owner_valid;
   logic [DATA_WIDTH-1:0] w_owner_data;
   logic                 w_xfer;
   logic                 w_last;
   logic [IDW-1:0]       w_next_ptr;

   // distance of index i from the round-robin pointer, walking upward with wrap
   function automatic int unsigned rr_dist(input int unsigned i, input logic [IDW-1:0] p);
      return (i + NUM_REQ - 32'(p)) % NUM_REQ;
   endfunction

   // pick the valid producer closest to the pointer (ptr, ptr+1, ... wrapping)
   always_comb begin
      w_any  = 1'b0;
      w_pick = '0;
      w_best = NUM_REQ;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (req_valid[i] && (rr_dist(i, r_ptr) < w_best)) begin
            w_any  = 1'b1;
            w_best = rr_dist(i, r_ptr);
            w_pick = IDW'(i);
         end
      end
   end

   // select the current owner's valid and data word
   always_comb begin
      w_owner_valid = 1'b0;
      w_owner_data  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (r_owner == IDW'(i)) begin
            w_owner_valid = req_valid[i];
            w_owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign w_xfer     = (r_state == S_GRANT) && w_owner_valid && !fifo_full;
   assign w_last     = (r_beat_cnt == LAST_BEAT);
   assign w_next_ptr = (r_owner == LAST_ID) ? '0 : r_owner + 1'b1;

   // handshake and write strobe follow the registered state, so reset clears them at once
   always_comb begin
      req_ready    = '0;
      fifo_wr      = w_xfer;
      fifo_wr_data = w_xfer ? w_owner_data : '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = (r_state == S_GRANT) && (r_owner == IDW'(i)) && !fifo_full;
      end
   end

   // arbitration FSM with registered busy/grant_id
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_owner    <= '0;
         r_ptr      <= '0;
         r_beat_cnt <= '0;
         r_grant_id <= '0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_owner    <= w_pick;
                  r_beat_cnt <= '0;
                  r_grant_id <= w_pick;
                  r_busy     <= 1'b1;
                  r_state    <= S_GRANT;
               end
            end
            S_GRANT: begin
               // a dropped valid releases even while stalled; full alone never releases
               if (!w_owner_valid || (w_xfer && w_last)) begin
                  r_ptr      <= w_next_ptr;
                  r_grant_id <= '0;
                  r_busy     <= 1'b0;
                  r_state    <= S_IDLE;
               end else if (w_xfer) begin
                  r_beat_cnt <= r_beat_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign grant_id = r_grant_id;
   assign busy     = r_busy;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: producer queues, a small fifo
// model with random drain, and a transaction-level reference of the grant.
module tb_fifo_wr_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int BL = 4;
   localparam int FD = 8;

   logic              clock = 1'b0;
   logic              rst   = 1'b0;
   logic [NR-1:0]     req_valid;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_ready;
   logic              fifo_full;
   logic              fifo_wr;
   logic [DW-1:0]     fifo_wr_data;
   logic [1:0]        grant_id;
   logic              busy;

   always #5 clock = ~clock;

   fifo_wr_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .BURST_LEN  (BL)
   ) dut (
      .clock        (clock),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .fifo_full    (fifo_full),
      .fifo_wr      (fifo_wr),
      .fifo_wr_data (fifo_wr_data),
      .grant_id     (grant_id),
      .busy         (busy)
   );

   typedef logic [7:0] byte_q_t[$];

   int      n_tests = 0;
   int      n_fail  = 0;
   byte_q_t prod_q[NR];
   byte_q_t fifo_q;
   byte_q_t exp_rd_q;
   bit      en[NR];
   bit      force_full;
   int      rd_pct;
   int      m_owner;   // -1 when no grant is held
   int      m_ptr;
   int      m_beats;   // words delivered in the current grant
   int      cyc;
   int      wr_cnt;
   int      rd_cnt;
   bit      hist_wr[64];
   bit      hist_busy[64];
   int      hist_gid[64];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         req_valid[i] = en[i] && (prod_q[i].size() > 0);
         req_data[i*DW +: DW] = req_valid[i] ? prod_q[i][0] : 8'h00;
      end
      fifo_full = force_full || (fifo_q.size() >= FD);
   endtask

   // one clock cycle: drive, check outputs mid-cycle, advance over the edge
   task automatic step();
      bit             xfer;
      bit             found;
      bit             do_rd;
      logic           s_wr;
      logic [7:0]     s_data;
      logic [7:0]     rd;
      logic [31:0]    exp_ready;
      logic [31:0]    exp_data;
      drive();
      #2;
      xfer      = (m_owner >= 0) && req_valid[m_owner] && !fifo_full;
      exp_ready = 0;
      exp_data  = 0;
      if (m_owner >= 0 && !fifo_full) exp_ready = 32'(1) << m_owner;
      if (xfer) exp_data = 32'(prod_q[m_owner][0]);
      check("busy", 32'(busy), 32'(m_owner >= 0));
      check("grant_id", 32'(grant_id), (m_owner >= 0) ? 32'(m_owner) : 0);
      check("req_ready", 32'(req_ready), exp_ready);
      check("fifo_wr", 32'(fifo_wr), 32'(xfer));
      check("fifo_wr_data", 32'(fifo_wr_data), exp_data);
      check("wr_while_full", 32'(fifo_wr & fifo_full), 0);
      if (cyc < 64) begin
         hist_wr[cyc]   = fifo_wr;
         hist_busy[cyc] = busy;
         hist_gid[cyc]  = int'(grant_id);
      end
      s_wr   = fifo_wr;
      s_data = fifo_wr_data;
      do_rd  = (fifo_q.size() > 0) && ($urandom_range(99) < rd_pct);
      @(posedge clock);
      #1;
      if (do_rd) begin
         rd = fifo_q.pop_front();
         rd_cnt++;
         check("rd_data", 32'(rd), (exp_rd_q.size() > 0) ? 32'(exp_rd_q.pop_front()) : 32'hDEAD);
      end
      if (s_wr) begin
         fifo_q.push_back(s_data);
         wr_cnt++;
      end
      if (m_owner < 0) begin
         found = 1'b0;
         for (int k = 0; k < NR; k++) begin
            if (!found && req_valid[(m_ptr + k) % NR]) begin
               found   = 1'b1;
               m_owner = (m_ptr + k) % NR;
               m_beats = 0;
            end
         end
      end else if (!req_valid[m_owner]) begin
         m_ptr   = (m_owner + 1) % NR;
         m_owner = -1;
      end else if (xfer) begin
         exp_rd_q.push_back(prod_q[m_owner].pop_front());
         m_beats++;
         if (m_beats == BL) begin
            m_ptr   = (m_owner + 1) % NR;
            m_owner = -1;
         end
      end
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      for (int i = 0; i < NR; i++) begin
         prod_q[i].delete();
         en[i] = 1'b1;
      end
      fifo_q.delete();
      exp_rd_q.delete();
      force_full = 1'b0;
      rd_pct  = 0;
      m_owner = -1;
      m_ptr   = 0;
      m_beats = 0;
      cyc     = 0;
      wr_cnt  = 0;
      rd_cnt  = 0;
      for (int i = 0; i < 64; i++) begin
         hist_wr[i]   = 1'b0;
         hist_busy[i] = 1'b0;
         hist_gid[i]  = 0;
      end
      drive();
      repeat (2) @(posedge clock);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, required finish before timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [8:0] pat;
      int         gseq[$];
      int         w20;
      bit         done;

      // reset values while rst is held
      do_reset();
      rst = 1'b0;
      #1;
      check("reset_busy", 32'(busy), 0);
      check("reset_grant_id", 32'(grant_id), 0);
      check("reset_fifo_wr", 32'(fifo_wr), 0);
      check("reset_req_ready", 32'(req_ready), 0);

      // T1: single producer, six words, burst of 4 then re-grant
      do_reset();
      for (int v = 8'h10; v <= 8'h15; v++) prod_q[0].push_back(8'(v));
      repeat (9) step();
      pat = '0;
      for (int c = 0; c < 9; c++) pat = {pat[7:0], hist_wr[c]};
      check("T1_wr_pattern", 32'(pat), 32'b011110110);
      check("T1_wr_count", 32'(wr_cnt), 6);
      check("T1_regrant_id", 32'(hist_gid[6]), 0);

      // T2: all four valid continuously
      do_reset();
      rd_pct = 100;
      for (int i = 0; i < NR; i++)
         for (int n = 0; n < 8; n++) prod_q[i].push_back(8'($urandom));
      repeat (22) step();
      w20 = 0;
      for (int c = 0; c < 20; c++) w20 += int'(hist_wr[c]);
      check("T2_writes_in_20", 32'(w20), 16);
      for (int c = 0; c < 22; c++)
         if (hist_busy[c] && (c == 0 || !hist_busy[c-1])) gseq.push_back(hist_gid[c]);
      check("T2_num_grants", 32'(gseq.size()), 5);
      for (int k = 0; k < gseq.size(); k++) check("T2_grant_seq", 32'(gseq[k]), 32'(k % NR));

      // T3: full for three cycles after the second beat
      do_reset();
      for (int n = 0; n < 4; n++) prod_q[0].push_back(8'(8'h40 + n));
      for (int c = 0; c < 9; c++) begin
         force_full = (c >= 3 && c <= 5);
         step();
      end
      force_full = 1'b0;
      pat = '0;
      for (int c = 0; c < 9; c++) pat = {pat[7:0], hist_wr[c]};
      check("T3_wr_pattern", 32'(pat), 32'b011000110);
      check("T3_busy_held", 32'(hist_busy[5]), 1);

      // T4: owner 1 drops valid after two beats while req2 waits
      do_reset();
      for (int n = 0; n < 2; n++) prod_q[1].push_back(8'(8'h50 + n));
      for (int n = 0; n < 4; n++) prod_q[2].push_back(8'(8'h60 + n));
      repeat (8) step();
      check("T4_first_owner", 32'(hist_gid[1]), 1);
      check("T4_idle_gap", 32'(hist_busy[4]), 0);
      check("T4_next_owner", 32'(hist_gid[5]), 2);

      // T5: asynchronous reset during beat 2
      do_reset();
      for (int n = 0; n < 4; n++) prod_q[0].push_back(8'(8'h70 + n));
      step();
      step();
      drive();
      #2;
      check("T5_pre_wr", 32'(fifo_wr), 1);
      rst = 1'b0;
      #1;
      check("T5_async_wr", 32'(fifo_wr), 0);
      check("T5_async_ready", 32'(req_ready), 0);
      check("T5_async_busy", 32'(busy), 0);
      do_reset();
      for (int n = 0; n < 2; n++) begin
         prod_q[1].push_back(8'(8'h80 + n));
         prod_q[3].push_back(8'(8'h90 + n));
      end
      repeat (4) step();
      check("T5_first_grant", 32'(hist_gid[1]), 1);

      // T6: 20 random words, random valid drops, random full pressure and drain
      do_reset();
      rd_pct = 50;
      for (int n = 0; n < 20; n++) prod_q[$urandom_range(NR-1)].push_back(8'($urandom));
      done = 1'b0;
      for (int c = 0; c < 2000 && !done; c++) begin
         for (int i = 0; i < NR; i++) en[i] = ($urandom_range(9) < 8);
         force_full = ($urandom_range(9) < 2);
         step();
         done = (fifo_q.size() == 0);
         for (int i = 0; i < NR; i++) if (prod_q[i].size() != 0) done = 1'b0;
      end
      check("T6_drained", 32'(done), 1);
      check("T6_writes", 32'(wr_cnt), 20);
      check("T6_reads", 32'(rd_cnt), 20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
